// File: rtl/axil_write_engine_pkg.sv
// Shared types, error codes and BAR window helpers for the AXI-Lite write engine.
// Pure declarations; no state.
// Not applicable (no handshakes).
package axil_write_engine_pkg;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_SLVERR   = 2'b01;
  localparam logic [1:0] ERR_DECERR   = 2'b10;
  localparam logic [1:0] ERR_UNMAPPED = 2'b11;

  // bar(3) + pcie address(32) + byte enables(4) + data(32)
  localparam int REQ_W = 3 + 32 + 4 + 32;

  typedef struct packed {
    logic [2:0]  bar;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } req_t;

  // AW/W issue tracker: both channels pending, or only one still pending
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BOTH = 2'd1,
    ST_AW   = 2'd2,
    ST_W    = 2'd3
  } iss_st_t;

  function automatic logic [63:0] bar_base(input logic [383:0] bases, input int n);
    return bases[64*n +: 64];
  endfunction

  function automatic logic [5:0] bar_size(input logic [35:0] sizes, input int n);
    return sizes[6*n +: 6];
  endfunction

  // Keep base bits above the aperture, take the offset bits below it, DW-align.
  function automatic logic [63:0] bar_xlate(input logic [63:0] base, input logic [5:0] size,
                                            input logic [31:0] pcie);
    logic [63:0] mask;
    mask = (64'd1 << size) - 64'd1;
    return ((base & ~mask) | ({32'd0, pcie} & mask)) & ~64'd3;
  endfunction

endpackage

// File: rtl/axil_wr_req_fifo.sv
// Synchronous request FIFO with first-word-fall-through head.
// Head valid the cycle after the push that makes the FIFO non-empty.
// Caller must not push when o_full nor pop when o_empty.
module axil_wr_req_fifo #(
  parameter int WIDTH = 71,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  // Pointer bookkeeping; the extra MSB distinguishes full from empty
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end

  assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/axil_write_engine.sv
// Buffers decoded PCIe memory writes, maps BAR offsets into AXI space, issues AXI4-Lite writes.
// AW/W valid one cycle after a mapped head appears; one write per 2 cycles at best.
// mem_req_ready drops when the FIFO is full; issue stalls at MAX_OUTSTANDING unanswered writes.
module axil_write_engine
  import axil_write_engine_pkg::*;
#(
  parameter int           TCQ               = 1,
  parameter int           M_AXI_TDATA_WIDTH = 32,
  parameter int           M_AXI_ADDR_WIDTH  = 32,
  parameter int           NUM_BARS          = 6,
  parameter logic [383:0] BAR_AXI_BASE      = 384'h0,
  parameter logic [35:0]  BAR_SIZE          = 36'h30C30C30C,
  parameter int           REQ_FIFO_DEPTH    = 4,
  parameter int           MAX_OUTSTANDING   = 4
) (
  input  logic                           m_axi_aclk,
  input  logic                           m_axi_areset,
  output logic [M_AXI_ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic [2:0]                     m_axi_awprot,
  output logic                           m_axi_awvalid,
  input  logic                           m_axi_awready,
  output logic [M_AXI_TDATA_WIDTH-1:0]   m_axi_wdata,
  output logic [M_AXI_TDATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                           m_axi_wvalid,
  input  logic                           m_axi_wready,
  input  logic [1:0]                     m_axi_bresp,
  input  logic                           m_axi_bvalid,
  output logic                           m_axi_bready,
  input  logic                           mem_req_valid,
  output logic                           mem_req_ready,
  input  logic [2:0]                     mem_req_bar_hit,
  input  logic [31:0]                    mem_req_pcie_address,
  input  logic [3:0]                     mem_req_byte_enable,
  input  logic                           mem_req_write_readn,
  input  logic                           mem_req_phys_func,
  input  logic [31:0]                    mem_req_write_data,
  output logic                           wr_err_valid,
  output logic [1:0]                     wr_err_code,
  output logic                           wr_idle
);

  req_t        w_in_req;
  req_t        w_head;
  logic        w_push, w_pop, w_full, w_empty;
  logic        w_mapped, w_can_issue, w_issue_done, w_um_pop;
  logic        w_aw_hs, w_w_hs, w_b_hs, w_b_err;
  logic [63:0] w_xlate;
  logic        w_unused;
  iss_st_t     r_state, w_state_nxt;
  logic [3:0]  r_outst;
  logic        r_um_pend;
  logic        r_err_vld;
  logic [1:0]  r_err_code;

  assign w_in_req      = '{bar: mem_req_bar_hit, addr: mem_req_pcie_address,
                           be: mem_req_byte_enable, data: mem_req_write_data};
  assign mem_req_ready = !w_full && !m_axi_areset;
  assign w_push        = mem_req_valid && mem_req_ready && mem_req_write_readn;

  axil_wr_req_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_FIFO_DEPTH)) u_req_fifo (
    .i_clk   (m_axi_aclk),
    .i_rst   (m_axi_areset),
    .i_push  (w_push),
    .i_dat   (w_in_req),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_mapped = (int'(w_head.bar) < NUM_BARS);

  // Translate the head's BAR-relative address through its BAR window
  always_comb begin
    w_xlate = '0;
    for (int n = 0; n < NUM_BARS; n++) begin
      if (w_head.bar == 3'(n))
        w_xlate = bar_xlate(bar_base(BAR_AXI_BASE, n), bar_size(BAR_SIZE, n), w_head.addr);
    end
  end

  assign m_axi_awaddr = w_xlate[M_AXI_ADDR_WIDTH-1:0];
  assign m_axi_awprot = 3'b000;

  generate
    if (M_AXI_TDATA_WIDTH == 64) begin : g_dw64
      assign m_axi_wdata = {2{w_head.data}};
      assign m_axi_wstrb = w_head.addr[2] ? {w_head.be, 4'b0000} : {4'b0000, w_head.be};
    end else begin : g_dw32
      assign m_axi_wdata = w_head.data;
      assign m_axi_wstrb = w_head.be;
    end
  endgenerate

  assign w_aw_hs     = m_axi_awvalid && m_axi_awready;
  assign w_w_hs      = m_axi_wvalid && m_axi_wready;
  assign w_b_hs      = m_axi_bvalid && m_axi_bready;
  assign w_b_err     = w_b_hs && m_axi_bresp[1];
  assign w_can_issue = !w_empty && w_mapped && (int'(r_outst) < MAX_OUTSTANDING);
  // An unmapped head is dropped only while no earlier unmapped report is still queued
  assign w_um_pop    = (r_state == ST_IDLE) && !w_empty && !w_mapped && !r_um_pend;
  assign w_pop       = w_issue_done || w_um_pop;

  // Issue state register
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Next issue state: AW and W retire independently
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_can_issue) w_state_nxt = ST_BOTH;
      ST_BOTH: begin
        if (w_aw_hs && w_w_hs) w_state_nxt = ST_IDLE;
        else if (w_aw_hs)      w_state_nxt = ST_W;
        else if (w_w_hs)       w_state_nxt = ST_AW;
      end
      ST_AW:   if (w_aw_hs) w_state_nxt = ST_IDLE;
      ST_W:    if (w_w_hs)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Channel valids and the write-complete strobe that pops the head
  always_comb begin
    m_axi_awvalid = (r_state == ST_BOTH) || (r_state == ST_AW);
    m_axi_wvalid  = (r_state == ST_BOTH) || (r_state == ST_W);
    w_issue_done  = ((r_state == ST_BOTH) && m_axi_awready && m_axi_wready) ||
                    ((r_state == ST_AW) && m_axi_awready) ||
                    ((r_state == ST_W) && m_axi_wready);
  end

  // Outstanding-write counter: +1 at pop, -1 per accepted B
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      r_outst <= '0;
    end else begin
      case ({w_issue_done, w_b_hs})
        2'b10:   r_outst <= r_outst + 4'd1;
        2'b01:   r_outst <= r_outst - 4'd1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  assign m_axi_bready = (r_outst != 4'd0);

  // Error pulse: a B error wins the cycle, a colliding unmapped drop reports next cycle
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      r_err_vld  <= 1'b0;
      r_err_code <= ERR_NONE;
      r_um_pend  <= 1'b0;
    end else if (w_b_err) begin
      r_err_vld  <= 1'b1;
      r_err_code <= m_axi_bresp[0] ? ERR_DECERR : ERR_SLVERR;
      r_um_pend  <= r_um_pend || w_um_pop;
    end else if (w_um_pop || r_um_pend) begin
      r_err_vld  <= 1'b1;
      r_err_code <= ERR_UNMAPPED;
      r_um_pend  <= 1'b0;
    end else begin
      r_err_vld  <= 1'b0;
    end
  end

  assign wr_err_valid = r_err_vld;
  assign wr_err_code  = r_err_code;
  assign wr_idle      = w_empty && (r_outst == 4'd0) && (r_state == ST_IDLE);

  // Function id is carried for tracing only; TCQ affects simulation timing only
  assign w_unused = ^{mem_req_phys_func, (TCQ != 0), w_xlate, w_head.addr};

endmodule

// File: tb/tb_axil_write_engine.sv
// Directed bench for axil_write_engine: a 32-bit instance (depth 4, 2 outstanding)
// and a 64-bit instance (defaults) sharing clock, reset and request payload.
// Inputs change 1 time unit after the rising edge; handshakes are logged on the falling edge.
module tb_axil_write_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared request payload
  logic [2:0]  req_bar  = '0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be   = '0;
  logic        req_wr   = 1'b1;
  logic        req_pf   = 1'b0;
  logic [31:0] req_dat  = '0;

  // 32-bit instance
  logic [31:0] awaddr;  logic [2:0] awprot; logic awvalid; logic awready = 1'b0;
  logic [31:0] wdata;   logic [3:0] wstrb;  logic wvalid;  logic wready  = 1'b0;
  logic [1:0]  bresp = '0; logic bvalid = 1'b0; logic bready;
  logic req_vld = 1'b0; logic req_rdy; logic err_vld; logic [1:0] err_code; logic idle;

  // 64-bit instance
  logic [31:0] x_awaddr; logic [2:0] x_awprot; logic x_awvalid; logic x_awready = 1'b0;
  logic [63:0] x_wdata;  logic [7:0] x_wstrb;  logic x_wvalid;  logic x_wready  = 1'b0;
  logic [1:0]  x_bresp = '0; logic x_bvalid = 1'b0; logic x_bready;
  logic x_req_vld = 1'b0; logic x_req_rdy; logic x_err_vld; logic [1:0] x_err_code; logic x_idle;

  axil_write_engine #(
    .M_AXI_TDATA_WIDTH(32), .M_AXI_ADDR_WIDTH(32), .NUM_BARS(6),
    .BAR_AXI_BASE({256'h0, 64'h0000_0000_8000_0000, 64'h0000_0000_4000_0000}),
    .BAR_SIZE(36'h30C30C40C), .REQ_FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
  ) u_dut32 (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .mem_req_valid(req_vld), .mem_req_ready(req_rdy), .mem_req_bar_hit(req_bar),
    .mem_req_pcie_address(req_addr), .mem_req_byte_enable(req_be),
    .mem_req_write_readn(req_wr), .mem_req_phys_func(req_pf), .mem_req_write_data(req_dat),
    .wr_err_valid(err_vld), .wr_err_code(err_code), .wr_idle(idle)
  );

  axil_write_engine #(.M_AXI_TDATA_WIDTH(64)) u_dut64 (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .m_axi_awaddr(x_awaddr), .m_axi_awprot(x_awprot), .m_axi_awvalid(x_awvalid), .m_axi_awready(x_awready),
    .m_axi_wdata(x_wdata), .m_axi_wstrb(x_wstrb), .m_axi_wvalid(x_wvalid), .m_axi_wready(x_wready),
    .m_axi_bresp(x_bresp), .m_axi_bvalid(x_bvalid), .m_axi_bready(x_bready),
    .mem_req_valid(x_req_vld), .mem_req_ready(x_req_rdy), .mem_req_bar_hit(req_bar),
    .mem_req_pcie_address(req_addr), .mem_req_byte_enable(req_be),
    .mem_req_write_readn(req_wr), .mem_req_phys_func(req_pf), .mem_req_write_data(req_dat),
    .wr_err_valid(x_err_vld), .wr_err_code(x_err_code), .wr_idle(x_idle)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];

  // log completed AW/W handshakes of the 32-bit instance
  always @(negedge clk) begin
    if (awvalid && awready) aw_q.push_back(awaddr);
    if (wvalid && wready)   w_q.push_back(wdata);
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit sel, input logic [2:0] bar, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    int n;
    req_bar = bar; req_addr = a; req_be = be; req_dat = d; req_wr = 1'b1;
    if (sel) x_req_vld = 1'b1; else req_vld = 1'b1;
    #1;
    n = 0;
    while (((sel ? x_req_rdy : req_rdy) == 1'b0) && n < 200) begin
      step(); #1; n++;
    end
    check_vec("push_ready_wait", 64'(n < 200), 64'd1);
    step();
    req_vld = 1'b0; x_req_vld = 1'b0;
  endtask

  initial begin
    int base_cnt;
    // ---------------- reset ----------------
    repeat (3) step();
    check_vec("rdy_in_reset", req_rdy, 0);
    rst = 1'b0;
    #1;
    check_vec("rdy_after_reset", req_rdy, 1);
    check_vec("idle_after_reset", idle, 1);
    check_vec("awvalid_reset", awvalid, 0);
    check_vec("wvalid_reset", wvalid, 0);
    check_vec("bready_reset", bready, 0);
    check_vec("err_vld_reset", err_vld, 0);
    check_vec("err_code_reset", err_code, 0);
    check_vec("awprot", awprot, 0);

    // ---------------- single write, BAR0 ----------------
    awready = 1'b1; wready = 1'b1;
    push(0, 3'd0, 32'h0000_0A14, 4'hF, 32'hDEAD_BEEF);
    step();
    check_vec("t1_awvalid", awvalid, 1);
    check_vec("t1_wvalid", wvalid, 1);
    check_vec("t1_awaddr", awaddr, 32'h4000_0A14);
    check_vec("t1_wdata", wdata, 32'hDEAD_BEEF);
    check_vec("t1_wstrb", wstrb, 4'hF);
    step();
    check_vec("t1_awvalid_drop", awvalid, 0);
    check_vec("t1_bready", bready, 1);
    check_vec("t1_busy", idle, 0);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    check_vec("t1_idle_after_b", idle, 1);
    check_vec("t1_no_err", err_vld, 0);

    // ---------------- BAR1 (size 16) + SLVERR ----------------
    push(0, 3'd1, 32'h1234_5678, 4'h5, 32'h0BAD_F00D);
    step();
    check_vec("t2_awaddr", awaddr, 32'h8000_5678);
    check_vec("t2_wstrb", wstrb, 4'h5);
    step();
    bvalid = 1'b1; bresp = 2'b10;
    step();
    bvalid = 1'b0; bresp = 2'b00;
    check_vec("t2_slverr_vld", err_vld, 1);
    check_vec("t2_slverr_code", err_code, 2'b01);
    step();
    check_vec("t2_pulse_len", err_vld, 0);
    check_vec("t2_code_held", err_code, 2'b01);

    // ---------------- DECERR ----------------
    push(0, 3'd0, 32'h0000_0000, 4'hF, 32'h1);
    step(); step();
    bvalid = 1'b1; bresp = 2'b11;
    step();
    bvalid = 1'b0; bresp = 2'b00;
    check_vec("t2_decerr_code", {err_vld, err_code}, 3'b110);

    // ---------------- AW/W split ----------------
    base_cnt = aw_q.size();
    awready = 1'b0; wready = 1'b1;
    push(0, 3'd0, 32'h0000_0040, 4'hF, 32'h5555_AAAA);
    step();
    check_vec("t3_both_valid", {awvalid, wvalid}, 2'b11);
    step();
    check_vec("t3_w_only_done", {awvalid, wvalid}, 2'b10);
    step();
    check_vec("t3_aw_hold1", awvalid, 1);
    step();
    check_vec("t3_aw_hold2", awvalid, 1);
    awready = 1'b1;
    step();
    check_vec("t3_aw_done", {awvalid, wvalid}, 2'b00);
    check_vec("t3_outstanding", bready, 1);
    step();
    check_vec("t3_one_aw", aw_q.size() - base_cnt, 1);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    check_vec("t3_idle", idle, 1);

    // ---------------- backpressure ----------------
    aw_q.delete(); w_q.delete();
    awready = 1'b1; wready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) push(0, 3'd0, 32'h100 + 32'(4*i), 4'hF, 32'hA0 + 32'(i));
      end
      begin
        repeat (30) step();
        check_vec("t4_aw_capped", aw_q.size(), 2);
        check_vec("t4_fifo_full_rdy", req_rdy, 0);
        bvalid = 1'b1;
      end
    join
    for (int k = 0; k < 200 && !idle; k++) step();
    check_vec("t4_drained", idle, 1);
    bvalid = 1'b0;
    check_vec("t4_aw_total", aw_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check_vec($sformatf("t4_awaddr%0d", i), (aw_q.size() > i) ? aw_q[i] : 32'h0, 32'h4000_0100 + 32'(4*i));
      check_vec($sformatf("t4_wdata%0d", i), (w_q.size() > i) ? w_q[i] : 32'h0, 32'hA0 + 32'(i));
    end

    // ---------------- read request is not consumed ----------------
    req_wr = 1'b0; req_vld = 1'b1; req_bar = 3'd0;
    step();
    req_vld = 1'b0; req_wr = 1'b1;
    step();
    check_vec("t5_read_ignored", {idle, awvalid}, 2'b10);

    // ---------------- unmapped BAR ----------------
    base_cnt = aw_q.size();
    push(0, 3'd6, 32'h0000_0000, 4'hF, 32'h0);
    step();
    check_vec("t6_um_pulse", {err_vld, err_code}, 3'b111);
    check_vec("t6_no_aw", awvalid, 0);
    step();
    check_vec("t6_um_pulse_end", {err_vld, err_code}, 3'b011);
    check_vec("t6_idle", idle, 1);
    check_vec("t6_aw_count", aw_q.size() - base_cnt, 0);

    // ---------------- B error and unmapped drop collide ----------------
    push(0, 3'd0, 32'h0000_0020, 4'hF, 32'h7);
    step(); step();
    push(0, 3'd7, 32'h0000_0000, 4'hF, 32'h0);
    bvalid = 1'b1; bresp = 2'b10;
    step();
    bvalid = 1'b0; bresp = 2'b00;
    check_vec("t7_b_first", {err_vld, err_code}, 3'b101);
    step();
    check_vec("t7_um_second", {err_vld, err_code}, 3'b111);
    step();
    check_vec("t7_pulse_end", err_vld, 0);

    // ---------------- 64-bit lanes, then reset mid-flight ----------------
    x_awready = 1'b1; x_wready = 1'b1;
    push(1, 3'd0, 32'h0000_0104, 4'h3, 32'hCAFE_1234);
    step();
    check_vec("t8_awaddr", x_awaddr, 32'h0000_0104);
    check_vec("t8_wstrb_hi", x_wstrb, 8'h30);
    check_vec("t8_wdata", x_wdata, 64'hCAFE_1234_CAFE_1234);
    step();
    push(1, 3'd0, 32'h0000_0100, 4'hC, 32'h1111_2222);
    step();
    check_vec("t8_wstrb_lo", x_wstrb, 8'h0C);
    step();
    x_awready = 1'b0;
    push(1, 3'd0, 32'h0000_0108, 4'hF, 32'h3333_4444);
    step();
    check_vec("t9_aw_pending", x_awvalid, 1);
    check_vec("t9_two_outstanding", x_bready, 1);
    rst = 1'b1;
    step();
    check_vec("t9_rst_awvalid", x_awvalid, 0);
    check_vec("t9_rst_idle", x_idle, 1);
    check_vec("t9_rst_outstanding", x_bready, 0);
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
